// File: rtl/fpmul_issuer.sv
// fpmul_issuer: issues IEEE-754 operand pairs to a floating-point multiplier,
// tracks them in an in-flight FIFO and pairs each product with its operands.
//
// Ports:
//   clk, rst_n                  clock, asynchronous active-low reset
//   cmd_valid/cmd_ready, cmd_a/cmd_b    operand pairs from the sequencer
//   dut_valid/dut_ready, dut_a/dut_b    issue side toward the multiplier
//   res_valid/res_ready, res_data       product from the multiplier
//   rsp_valid/rsp_ready, rsp_a/b/z      paired response to the scoreboard
//   err_timeout, err_orphan             sticky error flags
//   issued_cnt, done_cnt                transaction counters
//
// Optional feature: define FPMUL_ISSUER_STATS_EN to build the transaction
// counters; otherwise issued_cnt/done_cnt are tied to zero.
module fpmul_issuer #(
  parameter int unsigned DEPTH   = 4,
  parameter int unsigned TIMEOUT = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_a,
  input  logic [31:0] cmd_b,
  output logic        dut_valid,
  input  logic        dut_ready,
  output logic [31:0] dut_a,
  output logic [31:0] dut_b,
  input  logic        res_valid,
  output logic        res_ready,
  input  logic [31:0] res_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_a,
  output logic [31:0] rsp_b,
  output logic [31:0] rsp_z,
  output logic        err_timeout,
  output logic        err_orphan,
  output logic [15:0] issued_cnt,
  output logic [15:0] done_cnt
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned WW = $clog2(TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, STALL} state_t;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
  } pair_t;

  state_t          state, state_next;
  logic            live;
  pair_t           mem [DEPTH];
  pair_t           head;
  logic [PW-1:0]   wptr, rptr;
  logic [CW-1:0]   count, count_next;
  logic [WW-1:0]   wd, wd_next;
  logic            cmd_fire, push, res_fire, pop, orphan, rsp_fire;

  // Handshake decode
  assign cmd_fire = cmd_valid & cmd_ready;
  assign push     = dut_valid & dut_ready;
  assign res_fire = res_valid & res_ready;
  assign pop      = res_fire & (count != '0);
  assign orphan   = res_fire & (count == '0);
  assign rsp_fire = rsp_valid & rsp_ready;

  // Ready/valid decode; live keeps readies low until the first edge out of reset
  assign cmd_ready = live & (state == IDLE) & (count < CW'(DEPTH));
  assign dut_valid = (state == DRIVE);
  assign res_ready = live & (~rsp_valid | rsp_ready);

  assign head       = mem[rptr];
  assign count_next = count + CW'(push) - CW'(pop);

  // Out-of-reset marker
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) live <= 1'b0;
    else        live <= 1'b1;
  end

  // Issue FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Issue FSM next state
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cmd_fire) state_next = DRIVE;
      DRIVE:   if (push) state_next = (count_next < CW'(DEPTH)) ? IDLE : STALL;
      STALL:   if (count < CW'(DEPTH)) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Operand register presented to the multiplier
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dut_a <= '0;
      dut_b <= '0;
    end else if (cmd_fire) begin
      dut_a <= cmd_a;
      dut_b <= cmd_b;
    end
  end

  // In-flight FIFO storage (no reset needed; validity is tracked by count)
  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= '{a: dut_a, b: dut_b};
  end

  // In-flight FIFO pointers and occupancy
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (push) wptr <= wptr + PW'(1);
      if (pop)  rptr <= rptr + PW'(1);
      count <= count_next;
    end
  end

  // Response register; an orphan result never reaches it
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_a     <= '0;
      rsp_b     <= '0;
      rsp_z     <= '0;
    end else if (pop) begin
      rsp_valid <= 1'b1;
      rsp_a     <= head.a;
      rsp_b     <= head.b;
      rsp_z     <= res_data;
    end else if (rsp_fire) begin
      rsp_valid <= 1'b0;
    end
  end

  // Watchdog: counts idle cycles while work is outstanding, saturating
  always_comb begin
    wd_next = wd;
    if (res_fire || (count == '0)) wd_next = '0;
    else if (wd != WW'(TIMEOUT))   wd_next = wd + WW'(1);
  end

  // Watchdog register and sticky error flags
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wd          <= '0;
      err_timeout <= 1'b0;
      err_orphan  <= 1'b0;
    end else begin
      wd <= wd_next;
      if (wd_next == WW'(TIMEOUT)) err_timeout <= 1'b1;
      if (orphan)                  err_orphan  <= 1'b1;
    end
  end

`ifdef FPMUL_ISSUER_STATS_EN
  // Transaction counters, wrapping at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      issued_cnt <= '0;
      done_cnt   <= '0;
    end else begin
      if (push)     issued_cnt <= issued_cnt + 16'd1;
      if (rsp_fire) done_cnt   <= done_cnt + 16'd1;
    end
  end
`else
  assign issued_cnt = '0;
  assign done_cnt   = '0;
`endif

endmodule

// File: tb/tb_fpmul_issuer.sv
// Self-checking bench for fpmul_issuer: directed scenarios plus randomized
// traffic, checked against an in-order scoreboard and a queue-based
// multiplier model.
module tb_fpmul_issuer;

  logic        clk, rst_n;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_a, cmd_b;
  logic        dut_valid, dut_ready;
  logic [31:0] dut_a, dut_b;
  logic        res_valid, res_ready;
  logic [31:0] res_data;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_a, rsp_b, rsp_z;
  logic        err_timeout, err_orphan;
  logic [15:0] issued_cnt, done_cnt;

  fpmul_issuer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .dut_valid(dut_valid), .dut_ready(dut_ready), .dut_a(dut_a), .dut_b(dut_b),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_a(rsp_a), .rsp_b(rsp_b), .rsp_z(rsp_z),
    .err_timeout(err_timeout), .err_orphan(err_orphan),
    .issued_cnt(issued_cnt), .done_cnt(done_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] z;
  } trip_t;

  trip_t cmd_q[$];    // commands waiting to be accepted
  trip_t issue_q[$];  // accepted, expected next on the issue port
  trip_t mul_q[$];    // issued to the multiplier model, awaiting result
  int    due_q[$];    // cycle at which each mul_q entry may return
  trip_t rsp_q[$];    // expected responses, in command order

  int errors = 0, checks = 0;
  int cyc = 0, n_issued = 0, n_rsp = 0, n_res = 0;
  int dr_mode = 1, rr_mode = 1, mul_lat = 6;
  bit mul_en = 1'b1, orphan_req = 1'b0, orphan_active = 1'b0;
  bit prev_pop = 1'b0, prev_sf = 1'b0;

  // Multiplier stand-in: the one directed operand pair returns its real product
  function automatic logic [31:0] prod(input logic [31:0] a, input logic [31:0] b);
    if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
    return a ^ {b[15:0], b[31:16]} ^ 32'h5A5A_0000;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic add_cmd(input logic [31:0] a, input logic [31:0] b);
    trip_t t;
    t.a = a; t.b = b; t.z = prod(a, b);
    cmd_q.push_back(t);
    rsp_q.push_back(t);
  endtask

  // One clock: sample transfers at negedge, update models and drive after posedge
  task automatic cycle();
    bit cf, df, rf, sf;
    trip_t e;
    @(negedge clk);
    if (prev_pop)     check("rsp_after_pop", 32'(rsp_valid), 32'd1);
    else if (prev_sf) check("rsp_clear", 32'(rsp_valid), 32'd0);
    cf = cmd_valid && cmd_ready;
    df = dut_valid && dut_ready;
    rf = res_valid && res_ready;
    sf = rsp_valid && rsp_ready;
    if (df) begin
      if (issue_q.size() == 0) check("issue_extra", 32'(issue_q.size()), 32'd1);
      else begin
        check("issue_a", dut_a, issue_q[0].a);
        check("issue_b", dut_b, issue_q[0].b);
        mul_q.push_back(issue_q.pop_front());
        due_q.push_back(cyc + ((mul_lat == 0) ? int'($urandom_range(1, 6)) : mul_lat));
      end
      n_issued++;
    end
    if (sf) begin
      if (rsp_q.size() == 0) check("rsp_extra", 32'(rsp_q.size()), 32'd1);
      else begin
        e = rsp_q.pop_front();
        check("rsp_a", rsp_a, e.a);
        check("rsp_b", rsp_b, e.b);
        check("rsp_z", rsp_z, e.z);
      end
      n_rsp++;
    end
    prev_pop = rf && !orphan_active;
    prev_sf  = sf;
    @(posedge clk);
    #1;
    cyc++;
    if (cf) begin
      cmd_valid = 1'b0;
      issue_q.push_back(cmd_q.pop_front());
    end
    if (rf) begin
      if (orphan_active) orphan_active = 1'b0;
      else if (mul_q.size() > 0) begin
        mul_q.delete(0);
        due_q.delete(0);
        n_res++;
      end
    end
    if (!cmd_valid && cmd_q.size() > 0) begin
      cmd_valid = 1'b1;
      cmd_a = cmd_q[0].a;
      cmd_b = cmd_q[0].b;
    end
    case (dr_mode)
      0:       dut_ready = 1'b0;
      1:       dut_ready = 1'b1;
      default: dut_ready = 1'($urandom_range(0, 1));
    endcase
    case (rr_mode)
      0:       rsp_ready = 1'b0;
      1:       rsp_ready = 1'b1;
      2:       rsp_ready = 1'($urandom_range(0, 1));
      default: rsp_ready = ~rsp_ready;
    endcase
    if (orphan_active) begin
      res_valid = 1'b1;
    end else if (orphan_req) begin
      orphan_req = 1'b0;
      orphan_active = 1'b1;
      res_valid = 1'b1;
      res_data = 32'hDEAD_BEEF;
    end else if (mul_en && mul_q.size() > 0 && due_q[0] <= cyc) begin
      res_valid = 1'b1;
      res_data = mul_q[0].z;
    end else begin
      res_valid = 1'b0;
    end
    #1;
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while ((cmd_q.size() + issue_q.size() + mul_q.size() + rsp_q.size()) != 0 && n < budget) begin
      cycle();
      n++;
    end
    check("drain_left", 32'(cmd_q.size() + issue_q.size() + mul_q.size() + rsp_q.size()), 32'd0);
    repeat (2) cycle();
  endtask

  task automatic wait_issued(input int target, input int budget);
    int n = 0;
    while (n_issued < target && n < budget) begin
      cycle();
      n++;
    end
    check("issue_wait", 32'(n_issued >= target), 32'd1);
  endtask

  task automatic stats_check(input string tag);
`ifdef FPMUL_ISSUER_STATS_EN
    check({tag, "_issued"}, 32'(issued_cnt), 32'(16'(n_issued)));
    check({tag, "_done"}, 32'(done_cnt), 32'(16'(n_rsp)));
`else
    check({tag, "_issued"}, 32'(issued_cnt), 32'd0);
    check({tag, "_done"}, 32'(done_cnt), 32'd0);
`endif
  endtask

  task automatic reset_values(input string tag);
    check({tag, "_cmd_ready"}, 32'(cmd_ready), 32'd0);
    check({tag, "_dut_valid"}, 32'(dut_valid), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_res_ready"}, 32'(res_ready), 32'd0);
    check({tag, "_dut_a"}, dut_a, 32'd0);
    check({tag, "_rsp_z"}, rsp_z, 32'd0);
    check({tag, "_errs"}, 32'({err_timeout, err_orphan}), 32'd0);
    check({tag, "_issued_cnt"}, 32'(issued_cnt), 32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] hold_a, hold_b, z_before;
    int base, res0, n;
    rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0;
    dut_ready = 1'b0; res_valid = 1'b0; res_data = '0; rsp_ready = 1'b0;

    // Reset state, and readies held low until the first edge after release
    repeat (3) @(posedge clk);
    #2;
    reset_values("rst");
    rst_n = 1'b1;
    #1;
    check("rel_cmd_ready", 32'(cmd_ready), 32'd0);
    check("rel_res_ready", 32'(res_ready), 32'd0);
    cycle();
    check("live_cmd_ready", 32'(cmd_ready), 32'd1);
    check("live_res_ready", 32'(res_ready), 32'd1);

    // Single op: 2.0 * 3.0 with a 6-cycle multiplier
    dr_mode = 1; rr_mode = 1; mul_lat = 6;
    add_cmd(32'h4000_0000, 32'h4040_0000);
    drain(60);
    check("single_rsp_cnt", 32'(n_rsp), 32'd1);
    stats_check("single");

    // Back-pressure: dut_ready low for 10 cycles
    dr_mode = 0;
    add_cmd(32'h3F80_0000, 32'hC120_0000);
    add_cmd(32'h1234_5678, 32'h9ABC_DEF0);
    repeat (3) cycle();
    hold_a = 32'h3F80_0000; hold_b = 32'hC120_0000;
    for (int i = 0; i < 10; i++) begin
      cycle();
      check("bp_valid", 32'(dut_valid), 32'd1);
      check("bp_a", dut_a, hold_a);
      check("bp_b", dut_b, hold_b);
      check("bp_cmd_ready", 32'(cmd_ready), 32'd0);
    end
    dr_mode = 1;
    drain(100);

    // Fill: 5 commands, no results, depth 4
    mul_en = 1'b0; mul_lat = 2;
    base = n_issued;
    for (int i = 0; i < 5; i++) add_cmd($urandom, $urandom);
    repeat (20) cycle();
    check("fill_issued", 32'(n_issued - base), 32'd4);
    check("fill_pending", 32'(cmd_q.size()), 32'd1);
    check("fill_cmd_ready", 32'(cmd_ready), 32'd0);
    check("fill_dut_valid", 32'(dut_valid), 32'd0);
    res0 = n_res;
    mul_en = 1'b1;
    n = 0;
    while (cmd_q.size() != 0 && n < 40) begin
      cycle();
      n++;
    end
    check("fifth_after_res", 32'(n_res > res0), 32'd1);
    drain(100);
    stats_check("fill");

    // Ordering under random issue back-pressure and toggled rsp_ready
    dr_mode = 2; rr_mode = 3; mul_lat = 0;
    for (int i = 0; i < 24; i++) add_cmd($urandom, $urandom);
    drain(2000);
    dr_mode = 1; rr_mode = 1;
    repeat (2) cycle();
    stats_check("order");

    // Orphan result with nothing in flight
    check("pre_orphan", 32'(err_orphan), 32'd0);
    z_before = rsp_z;
    base = n_rsp;
    orphan_req = 1'b1;
    repeat (4) cycle();
    check("orphan_flag", 32'(err_orphan), 32'd1);
    check("orphan_rsp_valid", 32'(rsp_valid), 32'd0);
    check("orphan_rsp_z", rsp_z, z_before);
    check("orphan_no_rsp", 32'(n_rsp - base), 32'd0);

    // Timeout: one op in flight, no result
    check("pre_timeout", 32'(err_timeout), 32'd0);
    mul_en = 1'b0; mul_lat = 1;
    base = n_issued;
    add_cmd($urandom, $urandom);
    wait_issued(base + 1, 20);
    repeat (50) cycle();
    check("timeout_early", 32'(err_timeout), 32'd0);
    repeat (20) cycle();
    check("timeout_flag", 32'(err_timeout), 32'd1);
    mul_en = 1'b1;
    drain(40);
    check("timeout_sticky", 32'(err_timeout), 32'd1);
    check("orphan_sticky", 32'(err_orphan), 32'd1);

    // Reset with 3 ops in flight
    mul_en = 1'b0;
    base = n_issued;
    for (int i = 0; i < 3; i++) add_cmd($urandom, $urandom);
    wait_issued(base + 3, 40);
    rst_n = 1'b0;
    cmd_q.delete(); issue_q.delete(); mul_q.delete(); due_q.delete(); rsp_q.delete();
    cmd_valid = 1'b0; res_valid = 1'b0;
    prev_pop = 1'b0; prev_sf = 1'b0;
    n_issued = 0; n_rsp = 0;
    #1;
    reset_values("midrst");
    repeat (2) cycle();
    rst_n = 1'b1;
    mul_en = 1'b1;
    repeat (30) cycle();
    check("post_rst_no_rsp", 32'(n_rsp), 32'd0);
    check("post_rst_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_rst_cmd_ready", 32'(cmd_ready), 32'd1);
    stats_check("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
